// File: rtl/latency_stamp_tx_if.sv
// Enable and TX-side signal bundle between the test sequencer/GT user ports and latency_stamp_tx.
interface latency_stamp_tx_if;
    logic        valid_i;
    logic [15:0] tx_data_o;
    logic [1:0]  tx_k_o;
    logic [15:0] timestamp_o;
    logic        done_o;
    logic [31:0] data_cnt_o;

    modport master (
        output valid_i,
        input  tx_data_o, tx_k_o, timestamp_o, done_o, data_cnt_o
    );

    modport slave (
        input  valid_i,
        output tx_data_o, tx_k_o, timestamp_o, done_o, data_cnt_o
    );
endinterface

// File: rtl/latency_stamp_tx.sv
// GT TX latency pattern source: free-running 16-bit timestamps framed by K28.5 IDLE words,
// with an initial IDLE burst for comma alignment and an optional stop after a fixed word count.
module latency_stamp_tx #(
    parameter logic [15:0] g_IDLE        = 16'hbc95,
    parameter int unsigned g_IDLE_PERIOD = 193,
    parameter int unsigned g_INIT_IDLES  = 64,
    parameter int unsigned g_NUM_DATA    = 1000
) (
    input logic             usrclk_i,
    input logic             rst_n_i,
    latency_stamp_tx_if.slave bus
);
    localparam int PER_W  = (g_IDLE_PERIOD > 2) ? $clog2(g_IDLE_PERIOD) : 1;
    localparam int INIT_W = (g_INIT_IDLES > 1) ? $clog2(g_INIT_IDLES) : 1;

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(g_IDLE_PERIOD - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(g_INIT_IDLES - 1);
    localparam logic [31:0]       NUM_LAST  = (g_NUM_DATA == 0) ? 32'd0 : 32'(g_NUM_DATA - 1);
    localparam bit                STOP_EN   = (g_NUM_DATA != 0);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] K_IDLE = 2'b10;
    localparam logic [1:0] K_DATA = 2'b00;

    logic [1:0]        state_reg;
    logic [15:0]       ts_reg;
    logic [15:0]       tx_data_reg;
    logic [1:0]        tx_k_reg;
    logic              done_reg;
    logic [31:0]       data_cnt_reg;
    logic [PER_W-1:0]  period_cnt_reg;
    logic [INIT_W-1:0] init_cnt_reg;

    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= ST_OFF;
            ts_reg         <= 16'd0;
            tx_data_reg    <= g_IDLE;
            tx_k_reg       <= K_IDLE;
            done_reg       <= 1'b0;
            data_cnt_reg   <= 32'd0;
            period_cnt_reg <= '0;
            init_cnt_reg   <= '0;
        end else begin
            // Time base keeps running in every state so the far end can track it continuously.
            ts_reg      <= ts_reg + 16'd1;
            tx_data_reg <= g_IDLE;
            tx_k_reg    <= K_IDLE;

            if (!bus.valid_i) begin
                state_reg      <= ST_OFF;
                done_reg       <= 1'b0;
                data_cnt_reg   <= 32'd0;
                period_cnt_reg <= '0;
                init_cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_OFF: begin
                        // The IDLE sent on the enabling edge is already the first INIT word.
                        if (g_INIT_IDLES == 1) begin
                            state_reg <= ST_DATA;
                        end else begin
                            state_reg    <= ST_INIT;
                            init_cnt_reg <= INIT_W'(1);
                        end
                    end
                    ST_INIT: begin
                        if (init_cnt_reg == INIT_LAST) begin
                            state_reg    <= ST_DATA;
                            init_cnt_reg <= '0;
                        end else begin
                            init_cnt_reg <= init_cnt_reg + INIT_W'(1);
                        end
                    end
                    ST_DATA: begin
                        period_cnt_reg <= (period_cnt_reg == PER_LAST) ? '0
                                                                       : period_cnt_reg + PER_W'(1);
                        if (period_cnt_reg != '0) begin
                            tx_data_reg <= ts_reg;
                            tx_k_reg    <= K_DATA;
                            if (data_cnt_reg != 32'hFFFF_FFFF)
                                data_cnt_reg <= data_cnt_reg + 32'd1;
                            if (STOP_EN && (data_cnt_reg == NUM_LAST))
                                state_reg <= ST_DONE;
                        end
                    end
                    default: begin
                        done_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.tx_data_o   = tx_data_reg;
    assign bus.tx_k_o      = tx_k_reg;
    assign bus.timestamp_o = ts_reg;
    assign bus.done_o      = done_reg;
    assign bus.data_cnt_o  = data_cnt_reg;

endmodule

// File: tb/tb_latency_stamp_tx.sv
// Bench for latency_stamp_tx: two instances (short stop-after-5 config and the unlimited default-size
// config) checked every cycle against an edge-index based reference model, plus literal scenario checks.
module tb_latency_stamp_tx;
    localparam logic [15:0] IDLE = 16'hbc95;
    localparam int P[2] = '{4, 193};
    localparam int I[2] = '{3, 64};
    localparam int N[2] = '{5, 0};

    logic clk = 1'b0;
    logic rst_n;

    latency_stamp_tx_if ifa ();
    latency_stamp_tx_if ifb ();

    latency_stamp_tx #(.g_IDLE(IDLE), .g_IDLE_PERIOD(4), .g_INIT_IDLES(3), .g_NUM_DATA(5)) dut_a (
        .usrclk_i(clk), .rst_n_i(rst_n), .bus(ifa)
    );
    latency_stamp_tx #(.g_IDLE(IDLE), .g_IDLE_PERIOD(193), .g_INIT_IDLES(64), .g_NUM_DATA(0)) dut_b (
        .usrclk_i(clk), .rst_n_i(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: each enabled edge gets an index since enable; words follow from that index.
    logic [15:0] m_ts[2];
    logic [15:0] m_word[2];
    logic [1:0]  m_k[2];
    logic        m_done[2];
    logic [31:0] m_cnt[2];
    int          m_idx[2];
    bit          m_fin[2];

    task automatic model_reset(input int i);
        m_ts[i] = 16'd0; m_word[i] = IDLE; m_k[i] = 2'b10; m_done[i] = 1'b0;
        m_cnt[i] = 32'd0; m_idx[i] = 0; m_fin[i] = 1'b0;
    endtask

    task automatic model_step(input int i, input logic v);
        m_word[i] = IDLE;
        m_k[i]    = 2'b10;
        if (!v) begin
            m_idx[i] = 0; m_fin[i] = 1'b0; m_cnt[i] = 32'd0; m_done[i] = 1'b0;
        end else begin
            m_done[i] = m_fin[i];
            if (!m_fin[i] && m_idx[i] >= I[i] && ((m_idx[i] - I[i]) % P[i]) != 0) begin
                m_word[i] = m_ts[i];
                m_k[i]    = 2'b00;
                if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
                if (N[i] != 0 && m_cnt[i] == 32'(N[i])) m_fin[i] = 1'b1;
            end
            m_idx[i] = m_idx[i] + 1;
        end
        m_ts[i] = m_ts[i] + 16'd1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, ifa.valid_i);
            model_step(1, ifb.valid_i);
        end
    end

    always @(negedge clk) begin
        if ($time > 0) begin
            check("a_data", {16'd0, ifa.tx_data_o}, {16'd0, m_word[0]});
            check("a_k", {30'd0, ifa.tx_k_o}, {30'd0, m_k[0]});
            check("a_ts", {16'd0, ifa.timestamp_o}, {16'd0, m_ts[0]});
            check("a_done", {31'd0, ifa.done_o}, {31'd0, m_done[0]});
            check("a_cnt", ifa.data_cnt_o, m_cnt[0]);
            check("b_data", {16'd0, ifb.tx_data_o}, {16'd0, m_word[1]});
            check("b_k", {30'd0, ifb.tx_k_o}, {30'd0, m_k[1]});
            check("b_ts", {16'd0, ifb.timestamp_o}, {16'd0, m_ts[1]});
            check("b_done", {31'd0, ifb.done_o}, {31'd0, m_done[1]});
            check("b_cnt", ifb.data_cnt_o, m_cnt[1]);
        end
    end

    // Enable A, drop it for a cycle, re-enable and wait (bounded) until it emits a timestamp.
    task automatic a_to_data(input string tag);
        bit seen;
        seen = 1'b0;
        ifa.valid_i = 1'b0;
        @(negedge clk);
        ifa.valid_i = 1'b1;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (ifa.tx_k_o == 2'b00) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    logic [15:0] rec_data[11];
    logic [1:0]  rec_k[11];
    logic        rec_done[11];
    logic [31:0] rec_cnt[11];

    initial begin
        int n_idle;
        int last_idle;
        bit found;
        logic [15:0] w[3];
        logic [1:0]  wk[3];

        rst_n = 1'b0;
        ifa.valid_i = 1'b1;
        ifb.valid_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", {16'd0, ifa.tx_data_o}, 32'h0000bc95);
        check("reset_k", {30'd0, ifa.tx_k_o}, 32'd2);
        check("reset_ts", {16'd0, ifa.timestamp_o}, 32'd0);
        rst_n = 1'b1;

        // Words after release with valid held: I I I I D D D I D D I, data = edge index.
        for (int e = 0; e < 11; e++) begin
            @(negedge clk);
            rec_data[e] = ifa.tx_data_o; rec_k[e] = ifa.tx_k_o;
            rec_done[e] = ifa.done_o;    rec_cnt[e] = ifa.data_cnt_o;
        end
        for (int e = 0; e < 11; e++) begin
            bit is_d;
            is_d = (e == 4 || e == 5 || e == 6 || e == 8 || e == 9);
            $display("edge %0d: data=%h k=%b done=%b cnt=%0d", e, rec_data[e], rec_k[e], rec_done[e], rec_cnt[e]);
            check("seq_k", {30'd0, rec_k[e]}, is_d ? 32'd0 : 32'd2);
            check("seq_data", {16'd0, rec_data[e]}, is_d ? 32'(e) : 32'h0000bc95);
            check("seq_done", {31'd0, rec_done[e]}, (e == 10) ? 32'd1 : 32'd0);
        end
        check("seq_cnt9", rec_cnt[9], 32'd5);
        check("seq_cnt10", rec_cnt[10], 32'd5);

        // Randomised enable on A.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ifa.valid_i = ($urandom_range(0, 15) != 0);
        end

        // One-cycle drop mid-DATA, then count IDLEs before the next timestamp.
        a_to_data("drop_reach_data");
        ifa.valid_i = 1'b0;
        @(negedge clk);
        check("drop_k", {30'd0, ifa.tx_k_o}, 32'd2);
        check("drop_data", {16'd0, ifa.tx_data_o}, 32'h0000bc95);
        check("drop_cnt", ifa.data_cnt_o, 32'd0);
        ifa.valid_i = 1'b1;
        n_idle = 0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (ifa.tx_k_o == 2'b00) found = 1'b1;
            else n_idle++;
        end
        $display("re-enable: %0d idles before data", n_idle);
        check("reenable_idles", 32'(n_idle), 32'd4);

        // Long unlimited run on B: never done, IDLEs exactly 193 words apart.
        last_idle = -1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            ifa.valid_i = ($urandom_range(0, 15) != 0);
            if (ifb.done_o !== 1'b0) check("b_unlimited_done", {31'd0, ifb.done_o}, 32'd0);
            if (ifb.tx_k_o == 2'b10) begin
                if (last_idle >= 0) check("b_idle_gap", 32'(c - last_idle), 32'd193);
                last_idle = c;
            end
        end
        check("b_done_after_run", {31'd0, ifb.done_o}, 32'd0);

        // Time-base wrap: enable B so its first data slots carry 0xFFFE, 0xFFFF, 0x0000.
        ifb.valid_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 70000 && !found; c++) begin
            @(negedge clk);
            if (ifb.timestamp_o == 16'hFFBD) found = 1'b1;
        end
        check("wrap_reach", {31'd0, found}, 32'd1);
        ifb.valid_i = 1'b1;
        for (int k = 0; k < 68; k++) begin
            @(negedge clk);
            if (k >= 65) begin w[k-65] = ifb.tx_data_o; wk[k-65] = ifb.tx_k_o; end
        end
        $display("wrap words: %h %h %h", w[0], w[1], w[2]);
        check("wrap_w0", {16'd0, w[0]}, 32'h0000FFFE);
        check("wrap_w1", {16'd0, w[1]}, 32'h0000FFFF);
        check("wrap_w2", {16'd0, w[2]}, 32'h00000000);
        check("wrap_k", {28'd0, wk[0], wk[2]}, 32'd0);

        // Asynchronous reset between edges while DATA is active.
        a_to_data("async_reach_data");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: data=%h k=%b ts=%h", ifa.tx_data_o, ifa.tx_k_o, ifa.timestamp_o);
        check("async_k", {30'd0, ifa.tx_k_o}, 32'd2);
        check("async_data", {16'd0, ifa.tx_data_o}, 32'h0000bc95);
        check("async_ts", {16'd0, ifa.timestamp_o}, 32'd0);
        check("async_b_ts", {16'd0, ifb.timestamp_o}, 32'd0);
        check("async_cnt", ifa.data_cnt_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/latency_stamp_tx.md
# latency_stamp_tx

Transmit-side pattern source for GT link latency characterisation. It drives the 16-bit TX data/K interface of a GT lane with free-running 16-bit timestamps, interleaved with K-coded IDLE words for comma alignment and clock correction. The far-end receive checker subtracts each received timestamp from its own copy of the time base, modulo 2^16, to measure latency. The block sits between the test sequencer (which enables it) and the GT TX user ports, in the `usrclk_i` domain.

## Interface
- `g_IDLE`, 16'hbc95, IDLE word; K28.5 (0xBC) in the upper byte, sent with `tx_k_o`=2'b10.
- `g_IDLE_PERIOD`, 193, words per data period; slot 0 is IDLE, slots 1..g_IDLE_PERIOD-1 are timestamps. Legal range ≥2.
- `g_INIT_IDLES`, 64, IDLE words sent after enable, before the first data period. Legal range ≥1.
- `g_NUM_DATA`, 1000, timestamp words to send before stopping; 0 = unlimited.
- `usrclk_i` in 1: GT TX user clock; the only clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `valid_i` in 1: enable; level-sensitive, sampled on `usrclk_i`.
- `tx_data_o` out 16: TX data word.
- `tx_k_o` out 2: TX charisk; 2'b10 on IDLE, 2'b00 on timestamp.
- `timestamp_o` out 16: current time-base value, for the local checker.
- `done_o` out 1: g_NUM_DATA timestamps sent.
- `data_cnt_o` out 32: timestamp words sent since the last enable.

## Operation
- Time base:
  - 16-bit counter, cleared by reset.
  - Increments on every `usrclk_i` edge regardless of state.
  - Wraps 0xFFFF→0x0000.
  - Drives `timestamp_o`.
- All outputs are registered. Reset values:
  - `tx_data_o`=g_IDLE, `tx_k_o`=2'b10
  - `timestamp_o`=0, `done_o`=0, `data_cnt_o`=0
  - state OFF
- State OFF:
  - Emits IDLE.
  - `valid_i`=1 → INIT. The IDLE emitted on this edge is INIT word 0.
- State INIT:
  - Emits IDLE, counts words.
  - After g_INIT_IDLES IDLE words in total, → DATA with the period counter at 0.
- State DATA:
  - Period counter runs 0..g_IDLE_PERIOD-1 and wraps.
  - Slot 0 → IDLE.
  - Other slots → `tx_data_o` = time-base value before this edge's increment, `tx_k_o`=2'b00, `data_cnt_o`+1.
  - When `data_cnt_o` reaches g_NUM_DATA (g_NUM_DATA≠0) → DONE.
- State DONE:
  - Emits IDLE. `done_o`=1 from the first IDLE after the last timestamp.
- `valid_i`=0 sampled in any state:
  - The word emitted on that edge is IDLE.
  - Next state is OFF; `done_o`←0, `data_cnt_o`←0, period and INIT counters←0.
  - Re-enable restarts from INIT. DONE does not restart while `valid_i` stays 1.
- Counters:
  - `data_cnt_o` saturates at 0xFFFFFFFF.
  - The time base never saturates.

## Timing
- Enable to first timestamp:
  - 1st edge sampling `valid_i`=1 → INIT word 0.
  - First timestamp appears on edge g_INIT_IDLES+1 (0-based): g_INIT_IDLES INIT IDLEs, then the slot-0 IDLE.
- Consecutive timestamps inside a period differ by exactly 1. Across a slot-0 IDLE they differ by exactly 2 (mod 2^16).
- `tx_data_o` on a data edge equals the `timestamp_o` value visible before that edge.
- Disable: `valid_i` sampled 0 on edge n → the edge-n word is IDLE and `done_o`=0 after edge n.
- Asynchronous reset mid-operation:
  - Outputs go to reset values immediately, without a clock.
  - Deassertion is synchronised externally; the block needs no internal synchroniser.

## Test plan
- Reset with `valid_i`=1 held, then release, using g_IDLE_PERIOD=4, g_INIT_IDLES=3, g_NUM_DATA=5:
  - Words from edge 0: I I I I D D D I D D I…
  - `done_o` rises with edge 10 and `data_cnt_o`=5.
- Same run: data words on edges 4,5,6 are t,t+1,t+2; edges 8,9 are t+4,t+5; all with `tx_k_o`=2'b00, and every IDLE is 0xbc95 with K=2'b10.
- Time-base wrap: force the counter to 0xFFFE before DATA → consecutive data words 0xFFFE, 0xFFFF, 0x0000.
- Drop `valid_i` for 1 cycle mid-DATA:
  - The word on that edge is IDLE and `data_cnt_o`=0.
  - Re-enable gives 3 INIT IDLEs plus the slot-0 IDLE before data.
- g_NUM_DATA=0 with g_IDLE_PERIOD=193: run 10000 cycles → `done_o` stays 0; exactly one IDLE per 193 words in DATA.
- Assert `rst_n_i`=0 asynchronously between edges while DATA is active → `tx_k_o`=2'b10, `tx_data_o`=0xbc95 and `timestamp_o`=0 before the next edge.
